// File: rtl/cc_orientation_detect_pkg.sv
// -----------------------------------------------------------------------------
// cc_orientation_detect_pkg
// Shared definitions for the Type-C attach/orientation detector.
//   - CC_ST_* / CC_ORIENT_* defines for blocks that only need the raw codes
//   - ccState_t : FSM state type used by the detector
//   - activePattern / isSinglePin : helpers on the synchronized {cc2, cc1} pair
// -----------------------------------------------------------------------------
`ifndef CC_ORIENT_DEFINES
`define CC_ORIENT_DEFINES
`define CC_ST_UNATTACHED  2'd0
`define CC_ST_ATTACH_WAIT 2'd1
`define CC_ST_ATTACHED    2'd2
`define CC_ST_DETACH_WAIT 2'd3
`define CC_ORIENT_CC1     1'b0
`define CC_ORIENT_CC2     1'b1
`endif

package cc_orientation_detect_pkg;

  typedef enum logic [1:0] {
    ST_UNATTACHED  = `CC_ST_UNATTACHED,
    ST_ATTACH_WAIT = `CC_ST_ATTACH_WAIT,
    ST_ATTACHED    = `CC_ST_ATTACHED,
    ST_DETACH_WAIT = `CC_ST_DETACH_WAIT
  } ccState_t;

  // Pattern {cc2, cc1} produced when only the given pin is terminated.
  function automatic logic [1:0] activePattern(input logic pin);
    return {pin, ~pin};
  endfunction

  // True for 01 or 10: exactly one CC pin shows a termination.
  function automatic logic isSinglePin(input logic [1:0] pattern);
    return pattern[1] ^ pattern[0];
  endfunction

endpackage

// File: rtl/cc_orientation_detect_sync_2ff.sv
// -----------------------------------------------------------------------------
// cc_sync_2ff
// Two-flop synchronizer for one asynchronous level input.
// Ports:
//   clk     : system clock
//   reset   : synchronous, active-high; clears both flops
//   i_async : asynchronous level input
//   o_sync  : level re-timed into the clk domain (2-cycle latency)
// -----------------------------------------------------------------------------
module cc_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/cc_orientation_detect.sv
// -----------------------------------------------------------------------------
// cc_orientation_detect
// Synchronizes and debounces the CC1/CC2 terminations, decides attach/detach
// and reports which CC pin is active.
// Ports:
//   clk          : system clock
//   reset        : synchronous, active-high
//   CC1, CC2     : raw asynchronous CC levels (1 = termination seen)
//   attached     : debounced attach status (high in ATTACHED and DETACH_WAIT)
//   orientation  : 0 = CC1 active, 1 = CC2 active; only updated on attach
//   attach_event : one-cycle pulse after the attach transition
//   detach_event : one-cycle pulse after the detach transition
//   cc_invalid   : synchronized CC1 and CC2 both high
//   state_dbg    : current FSM state code
// -----------------------------------------------------------------------------
module cc_orientation_detect
  import cc_orientation_detect_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CC1,
  input  logic       CC2,
  output logic       attached,
  output logic       orientation,
  output logic       attach_event,
  output logic       detach_event,
  output logic       cc_invalid,
  output logic [1:0] state_dbg
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

  logic             w_cc1Sync;
  logic             w_cc2Sync;
  logic [1:0]       w_pattern;
  ccState_t         r_state;
  ccState_t         w_stateNext;
  logic             r_cand;
  logic             w_candNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic [CNT_W-1:0] w_cntInc;
  logic             r_orientation;
  logic             w_orientationNext;
  logic             r_attachEvent;
  logic             w_attachEventNext;
  logic             r_detachEvent;
  logic             w_detachEventNext;

  cc_sync_2ff u_syncCc1 (
    .clk     (clk),
    .reset   (reset),
    .i_async (CC1),
    .o_sync  (w_cc1Sync)
  );

  cc_sync_2ff u_syncCc2 (
    .clk     (clk),
    .reset   (reset),
    .i_async (CC2),
    .o_sync  (w_cc2Sync)
  );

  assign w_pattern = {w_cc2Sync, w_cc1Sync};

  // Saturating increment so a long stable run can never wrap back to a
  // small count and delay the transition.
  assign w_cntInc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_ONE;

  // Next-state logic. The counter holds the number of consecutive qualifying
  // samples already seen, so the transition fires on the sample that finds
  // it at DEBOUNCE_CYCLES-1.
  always_comb begin
    w_stateNext       = r_state;
    w_candNext        = r_cand;
    w_cntNext         = r_cnt;
    w_orientationNext = r_orientation;
    w_attachEventNext = 1'b0;
    w_detachEventNext = 1'b0;
    case (r_state)
      ST_UNATTACHED: begin
        if (isSinglePin(w_pattern)) begin
          w_stateNext = ST_ATTACH_WAIT;
          w_candNext  = w_pattern[1];
          w_cntNext   = CNT_ONE;
        end else begin
          w_cntNext = '0;
        end
      end
      ST_ATTACH_WAIT: begin
        if (w_pattern == activePattern(r_cand)) begin
          if (r_cnt == CNT_LAST) begin
            w_stateNext       = ST_ATTACHED;
            w_orientationNext = r_cand;
            w_attachEventNext = 1'b1;
            w_cntNext         = '0;
          end else begin
            w_cntNext = w_cntInc;
          end
        end else if (isSinglePin(w_pattern)) begin
          // The other pin took over: restart debounce on the new candidate.
          w_candNext = w_pattern[1];
          w_cntNext  = CNT_ONE;
        end else begin
          w_stateNext = ST_UNATTACHED;
          w_cntNext   = '0;
        end
      end
      ST_ATTACHED: begin
        if (w_pattern != activePattern(r_orientation)) begin
          w_stateNext = ST_DETACH_WAIT;
          w_cntNext   = CNT_ONE;
        end
      end
      ST_DETACH_WAIT: begin
        if (w_pattern == activePattern(r_orientation)) begin
          w_stateNext = ST_ATTACHED;
          w_cntNext   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext       = ST_UNATTACHED;
          w_detachEventNext = 1'b1;
          w_cntNext         = '0;
        end else begin
          w_cntNext = w_cntInc;
        end
      end
      default: begin
        w_stateNext = ST_UNATTACHED;
        w_cntNext   = '0;
      end
    endcase
  end

  // State and event registers; reset wins over any pending transition so a
  // reset mid-debounce never produces an event pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_UNATTACHED;
      r_cand        <= 1'b0;
      r_cnt         <= '0;
      r_orientation <= `CC_ORIENT_CC1;
      r_attachEvent <= 1'b0;
      r_detachEvent <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_cand        <= w_candNext;
      r_cnt         <= w_cntNext;
      r_orientation <= w_orientationNext;
      r_attachEvent <= w_attachEventNext;
      r_detachEvent <= w_detachEventNext;
    end
  end

  assign attached     = (r_state == ST_ATTACHED) || (r_state == ST_DETACH_WAIT);
  assign orientation  = r_orientation;
  assign attach_event = r_attachEvent;
  assign detach_event = r_detachEvent;
  assign cc_invalid   = (w_pattern == 2'b11);
  assign state_dbg    = r_state;

endmodule

// File: doc/cc_orientation_detect.md
Name: cc_orientation_detect

Overview:
Type-C attach and orientation detector on the controller side, directly downstream of the USB host model's CC1/CC2 outputs. It synchronizes and debounces CC1/CC2, decides attach/detach, and reports which CC pin is active. The authentication and TX2 lane logic consume `orientation` and `attached` to select the lane and to gate the auth message exchange.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive stable synchronized samples needed to confirm attach or detach. Must be at least 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width. Localparam, derived.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high
- CC1  input  1  raw CC1 level (1 = termination detected), asynchronous
- CC2  input  1  raw CC2 level, asynchronous
- attached  output  1  debounced attach status
- orientation  output  1  0 = CC1 active, 1 = CC2 active; valid while attached
- attach_event  output  1  one-cycle pulse on the attach transition
- detach_event  output  1  one-cycle pulse on the detach transition
- cc_invalid  output  1  high while synchronized CC1 and CC2 are both 1
- state_dbg  output  2  current FSM state encoding

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high (`reset`). Reset clears all flops, puts the FSM in UNATTACHED, clears the counter, and drives all outputs to 0 (orientation=0, state_dbg=UNATTACHED).
- Synchronizer:
  - CC1 and CC2 each pass through 2 flops.
  - Synchronized pattern p = {cc2_s, cc1_s}: 01 = CC1 candidate, 10 = CC2 candidate, 00 = none, 11 = invalid.
- FSM states (encoding): UNATTACHED=0, ATTACH_WAIT=1, ATTACHED=2, DETACH_WAIT=3. Registers `cand` (1 bit) and `cnt` (CNT_W bits).
- UNATTACHED:
  - p=01 or p=10: go to ATTACH_WAIT; cand<=p[1]; cnt<=1.
  - p=00 or p=11: stay.
- ATTACH_WAIT:
  - p matches cand and cnt==DEBOUNCE_CYCLES-1: go to ATTACHED; orientation<=cand; attach_event=1 for one cycle.
  - p matches cand otherwise: cnt<=cnt+1.
  - p is the other single-pin pattern: restart with cand<=p[1], cnt<=1.
  - p=00 or p=11: go to UNATTACHED; cnt<=0.
- ATTACHED:
  - p equals the active pattern: stay.
  - Any other p: go to DETACH_WAIT; cnt<=1.
- DETACH_WAIT:
  - p equals the active pattern again: return to ATTACHED (glitch rejected); no events.
  - Otherwise cnt<=cnt+1.
  - When cnt==DEBOUNCE_CYCLES-1 and p still non-matching: go to UNATTACHED; detach_event=1 for one cycle.
- Attach latency: number the first rising edge that samples the new raw value as edge 1. `attached` and `attach_event` are high after edge DEBOUNCE_CYCLES+2. Detach latency is identical.
- Held outputs:
  - `attached` is 1 in ATTACHED and DETACH_WAIT only.
  - `orientation` holds its last value through detach and is never changed outside the attach transition.
- Counter: saturates and never wraps; the transition fires at DEBOUNCE_CYCLES-1.
- cc_invalid: combinational from the synchronized pattern (p==11). It does not itself force detach beyond the DETACH_WAIT rule.
- Reset mid-debounce: aborts immediately; no event pulse is emitted on that cycle.
- attach_event and detach_event are never high in the same cycle.

Decomposition:
- Shared defines file, alongside the existing `MSG_LEN define:
  - `CC_ST_UNATTACHED, `CC_ST_ATTACH_WAIT, `CC_ST_ATTACHED, `CC_ST_DETACH_WAIT.
  - `CC_ORIENT_CC1=0, `CC_ORIENT_CC2=1.
- One sub-module: cc_sync_2ff, a 2-flop synchronizer with synchronous reset, instantiated once per CC pin.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset held 2 cycles, CC1=CC2=0 -> all outputs 0, state_dbg=0; released and held 20 cycles -> no change.
- CC1 raised and held, CC2=0 -> attached=1, orientation=0, attach_event pulses exactly once, first seen after edge 6; then CC1 dropped -> detach_event one pulse after edge 6 of the drop, attached=0, orientation stays 0.
- CC2=1, CC1=0 held -> attach with orientation=1; then a 2-cycle CC2 low glitch -> state goes 2->3->2, attached stays 1, no events.
- CC1 high for 2 cycles then low (shorter than debounce) -> state reaches ATTACH_WAIT, returns to UNATTACHED, attached never 1, no pulses.
- Host-model sequence (CC2 falls while CC1 already high, 1-cycle overlap) -> cc_invalid high exactly 1 cycle, then attach with orientation=0; later swap so CC1 low and CC2 high -> detach then re-attach with orientation=1.
- Synchronous reset asserted on the third cycle of ATTACH_WAIT -> next cycle state=0, cnt=0, no attach_event.
